uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised successor to the UART transmitter.
- Accepts words through a valid/ready handshake into an internal FIFO and serialises them LSB-first onto the tx line.
- Data width, parity mode, stop-bit count and FIFO depth are configurable.
- Sits between the system-side producer and the tx pin of the UART interface; it feeds the receiver's error-detection path via the parity bit.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; DIV = CLK_FREQ / BAUD_RATE (integer truncation), must be >= 2
DATA_WIDTH, 8, data bits per frame, legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  DATA_WIDTH  word to transmit
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  FIFO can accept a word (= not full)
tx  output  1  serial line, idle high
busy  output  1  frame in progress (FSM not IDLE)
fifo_count  output  $clog2(FIFO_DEPTH+1)  words held in FIFO

Behaviour:
- Reset (reset = 0, asynchronous):
  - tx = 1, busy = 0, fifo_count = 0, tx_ready = 1.
  - FIFO pointers, baud counter, bit counter and shift register are cleared; FSM goes to IDLE.
  - A frame in flight is abandoned; no partial frame resumes after release.
- Handshake:
  - A word is written on a rising edge with tx_valid && tx_ready.
  - tx_ready is combinational from the full flag: low when fifo_count == FIFO_DEPTH.
  - tx_data is ignored when tx_valid = 0.
- Simultaneous push and pop:
  - If not full, both occur and fifo_count is unchanged.
  - When full, no push is possible that cycle, even if a pop occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If FIFO is non-empty, pop the head into the shift register, compute parity, load baud counter, enter START.
  - START: tx = 0 for DIV cycles.
  - DATA: tx = shift[0] for DIV cycles per bit, DATA_WIDTH bits, LSB first.
  - PARITY (only if PARITY_MODE != 0): tx = parity bit for DIV cycles.
    - Even mode: bit = XOR of data bits.
    - Odd mode: bit = inverted XOR of data bits.
  - STOP: tx = 1 for STOP_BITS*DIV cycles.
  - End of STOP: if FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- tx is a registered output.
- Latency:
  - Write into an empty FIFO while IDLE at edge N: pop at edge N+1, tx falls at edge N+1.
  - Frame length = (1 + DATA_WIDTH + (PARITY_MODE != 0) + STOP_BITS) * DIV cycles exactly.
- Word capture: a popped word is captured at pop time; later FIFO writes do not affect the current frame.
- Counters:
  - Baud counter counts DIV-1 down to 0; a bit boundary occurs on reaching 0.
  - Bit counter width is $clog2(DATA_WIDTH+1).
  - FIFO pointers have $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty are derived from fifo_count.
- busy = 1 from the pop edge through the last STOP cycle; it stays 1 across back-to-back frames.

Test Plan:
- Defaults (DIV = 868), single push of 0xA5 while idle -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 868 cycles; frame = 8680 cycles; busy drops afterwards; tx idles at 1.
- PARITY_MODE = 1, push 0xA5 then 0x07 -> parity bits 0 and 1; each frame 9548 cycles. PARITY_MODE = 2 with the same words -> parity bits 1 and 0.
- STOP_BITS = 2, PARITY_MODE = 0, push 0x55 and 0x0F back-to-back -> second start bit falls exactly 9548 cycles after the first; tx stays high for 1736 cycles before it.
- FIFO_DEPTH = 4, tx_valid held high with a new word each cycle while idle:
  - W0..W4 are accepted on five consecutive edges; fifo_count = 4 and tx_ready = 0 after the fifth.
  - W5 is accepted on the cycle after W1 is popped (end of frame 0).
  - Output order is W0, W1, W2, …
- DATA_WIDTH = 5, push 0x13 -> 7-bit frame 0,1,1,0,0,1,1, 6076 cycles.
- Reset asserted mid-frame during data bit 3:
  - tx = 1 immediately, before the next clk edge.
  - busy = 0, fifo_count = 0, tx_ready = 1.
  - After release with tx_valid = 0, tx remains 1 for 20000 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a valid/ready write port and an internal FIFO.
// Frames are start, DATA_WIDTH bits LSB-first, optional parity, then stop bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int DIV    = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W  = $clog2(DIV);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BAUD_LOAD  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT   = FCNT_W'(FIFO_DEPTH);
    localparam logic              HAS_PARITY = (PARITY_MODE != 0);
    localparam logic              PAR_INV    = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]     count_q, count_d;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  baud_done, start_frame;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign push     = tx_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign tx_ready = !full;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        start_frame = 1'b0;
        if (state_q != IDLE) baud_d = baud_done ? BAUD_LOAD : baud_q - CNT_W'(1);

        case (state_q)
            IDLE:   start_frame = !empty;
            START:  if (baud_done) state_d = DATA;
            DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: if (baud_done) state_d = STOP;
            STOP: begin
                if (baud_done) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d       = '0;
                        state_d     = IDLE;
                        start_frame = !empty;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping straight into START keeps back-to-back frames gapless.
        pop = start_frame;
        if (start_frame) begin
            state_d  = START;
            shift_d  = head;
            parity_d = (^head) ^ PAR_INV;
            baud_d   = BAUD_LOAD;
            bit_d    = '0;
        end

        // tx follows the next state so the line moves on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: instance A (8 bits, even parity, 2 stops, depth 4, DIV 4) and
// instance B (5 bits, odd parity, 1 stop, depth 2, DIV 3), checked bit by bit.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] tx_data_a;
    logic       tx_valid_a, tx_ready_a, tx_a, busy_a;
    logic [2:0] fifo_count_a;

    logic [4:0] tx_data_b;
    logic       tx_valid_b, tx_ready_b, tx_b, busy_b;
    logic [1:0] fifo_count_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] fill_words [6] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3};
    int         acc [6];
    logic [2:0] cnt5;
    logic       rdy5;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .DATA_WIDTH(8),
        .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
    );

    uart_tx_fifo #(
        .CLK_FREQ(300_000), .BAUD_RATE(100_000), .DATA_WIDTH(5),
        .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(2)
    ) dut_b (
        .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_tx(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    // Returns the number of negedges stepped until tx is low; -1 if the bound expires.
    task automatic wait_start(input int sel, input int limit, output int gap);
        gap = -1;
        for (int i = 0; i < limit; i++) begin
            if (cur_tx(sel) === 1'b0) begin
                gap = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // The current negedge is the first sample of the start bit.
    task automatic capture_frame(input int sel, input logic [8:0] data, input string tag);
        int   dw, div, stops, ones, nb, hits;
        logic odd;
        logic bits [16];
        dw    = (sel != 0) ? 5 : 8;
        div   = (sel != 0) ? 3 : 4;
        stops = (sel != 0) ? 1 : 2;
        odd   = (sel != 0);
        ones  = 0;
        bits[0] = 1'b0;
        for (int i = 0; i < dw; i++) begin
            bits[1 + i] = data[i];
            ones += int'(data[i]);
        end
        nb = 1 + dw;
        bits[nb] = ((ones % 2) == 1) ^ odd;
        nb++;
        for (int s = 0; s < stops; s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            hits = 0;
            for (int k = 0; k < div; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (cur_tx(sel) === bits[b]) hits++;
            end
            check($sformatf("%s bit%0d cycles", tag, b), hits, div);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, ok;
        reset      = 1'b0;
        tx_data_a  = '0;
        tx_valid_a = 1'b0;
        tx_data_b  = '0;
        tx_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst a tx", tx_a, 1);
        check("rst a busy", busy_a, 0);
        check("rst a count", fifo_count_a, 0);
        check("rst a ready", tx_ready_a, 1);
        check("rst b tx", tx_b, 1);
        check("rst b count", fifo_count_b, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single word while idle: tx falls one edge after the write.
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        check("a5 count after push", fifo_count_a, 1);
        check("a5 tx before pop", tx_a, 1);
        check("a5 busy before pop", busy_a, 0);
        wait_start(0, 10, gap);
        check("a5 latency", gap, 1);
        check("a5 busy at pop", busy_a, 1);
        check("a5 count at pop", fifo_count_a, 0);
        capture_frame(0, 9'h0A5, "a5");
        @(negedge clk);
        check("a5 tx idle after", tx_a, 1);
        check("a5 busy after", busy_a, 0);

        // Two words back to back: parity 1 then 0, no idle gap.
        tx_data_a = 8'h07; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_data_a = 8'h55;
        @(negedge clk);
        tx_valid_a = 1'b0;
        wait_start(0, 10, gap);
        check("b2b first gap", gap, 0);
        capture_frame(0, 9'h007, "a07");
        @(negedge clk);
        wait_start(0, 1, gap);
        check("b2b second gap", gap, 0);
        check("b2b busy held", busy_a, 1);
        capture_frame(0, 9'h055, "a55");
        @(negedge clk);
        check("b2b busy after", busy_a, 0);

        // FIFO fill with tx_valid held high.
        fork
            begin
                int idx, cyc;
                logic rdy;
                idx = 0;
                cyc = 0;
                tx_data_a  = fill_words[0];
                tx_valid_a = 1'b1;
                while (idx < 6 && cyc < 400) begin
                    rdy = tx_ready_a;
                    @(negedge clk);
                    cyc++;
                    if (rdy) begin
                        acc[idx] = cyc;
                        if (idx == 4) begin
                            cnt5 = fifo_count_a;
                            rdy5 = tx_ready_a;
                        end
                        idx++;
                        if (idx < 6) tx_data_a = fill_words[idx];
                        else tx_valid_a = 1'b0;
                    end
                end
                tx_valid_a = 1'b0;
                check("fill all accepted", idx, 6);
            end
            begin
                for (int w = 0; w < 6; w++) begin
                    int g;
                    if (w > 0) @(negedge clk);
                    wait_start(0, 60, g);
                    check($sformatf("fill w%0d gap", w), g, (w == 0) ? 2 : 0);
                    capture_frame(0, {1'b0, fill_words[w]}, $sformatf("fill w%0d", w));
                end
            end
        join
        for (int i = 0; i < 5; i++) check($sformatf("fill accept w%0d", i), acc[i], i + 1);
        check("fill count full", cnt5, 4);
        check("fill ready low", rdy5, 0);
        check("fill w5 accept delay", acc[5] - acc[0], 50);
        @(negedge clk);
        check("fill idle tx", tx_a, 1);
        check("fill idle busy", busy_a, 0);

        // Instance B: 5-bit words with odd parity.
        tx_data_b = 5'h13; tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        check("b13 count", fifo_count_b, 1);
        wait_start(1, 10, gap);
        check("b13 latency", gap, 1);
        capture_frame(1, 9'h013, "b13");
        @(negedge clk);
        check("b13 idle tx", tx_b, 1);
        check("b13 idle busy", busy_b, 0);
        tx_data_b = 5'h1F; tx_valid_b = 1'b1;
        @(negedge clk);
        tx_data_b = 5'h03;
        @(negedge clk);
        tx_valid_b = 1'b0;
        wait_start(1, 10, gap);
        check("b1f gap", gap, 0);
        capture_frame(1, 9'h01F, "b1f");
        @(negedge clk);
        wait_start(1, 1, gap);
        check("b03 gap", gap, 0);
        capture_frame(1, 9'h003, "b03");
        @(negedge clk);
        check("b03 idle busy", busy_b, 0);

        // Reset during data bit 3 of 0xA5 with two words still queued.
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_data_a = 8'h3C;
        @(negedge clk);
        tx_data_a = 8'h0F;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (16) @(negedge clk);
        check("mid bit3 tx", tx_a, 0);
        check("mid busy", busy_a, 1);
        check("mid count", fifo_count_a, 2);
        #1 reset = 1'b0;
        #1;
        check("async rst tx", tx_a, 1);
        check("async rst busy", busy_a, 0);
        check("async rst count", fifo_count_a, 0);
        check("async rst ready", tx_ready_a, 1);
        @(negedge clk);
        reset = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tx_data_a = 8'($urandom);
            @(negedge clk);
            if (tx_a === 1'b1 && busy_a === 1'b0 && fifo_count_a === 3'd0) ok++;
        end
        check("post rst quiet cycles", ok, 200);

        tx_data_a = 8'h3C; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        wait_start(0, 10, gap);
        check("recover latency", gap, 1);
        capture_frame(0, 9'h03C, "a3c");
        @(negedge clk);
        check("recover idle busy", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
